// File: rtl/nic8_bus_pkg.sv
// Shared definitions for the nic8 bus peripherals: transmitter FSM states,
// status-byte bit positions and default port addresses. Honours TX_PARITY_EN.
package nic8_bus_pkg;

    localparam logic [7:0] ADDR_DATA_DEF = 8'hFE;
    localparam logic [7:0] ADDR_STAT_DEF = 8'hFF;

    localparam int STAT_OVF   = 7;
    localparam int STAT_BUSY  = 6;
    localparam int STAT_FULL  = 5;
    localparam int STAT_EMPTY = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } txState_t;

    // Bit 3 is reserved and always reads 0; bits 2:0 carry the FIFO count.
    function automatic logic [7:0] statusByte(input logic ovf, input logic busy,
                                              input logic full, input logic empty,
                                              input logic [2:0] count);
        logic [7:0] s;
        s              = {5'b0, count};
        s[STAT_OVF]    = ovf;
        s[STAT_BUSY]   = busy;
        s[STAT_FULL]   = full;
        s[STAT_EMPTY]  = empty;
        return s;
    endfunction

endpackage

// File: rtl/bus_tx_port_fifo.sv
// tx_fifo4: 4-entry x 8-bit FIFO with combinational head. A push while full
// is taken only when a pop lands on the same edge.
module tx_fifo4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] dIn,
    output logic [7:0] dOut,
    output logic [2:0] count,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem [4];
    logic [1:0] wrPtr, rdPtr;
    logic       pushAcc, popAcc;

    assign full    = (count == 3'd4);
    assign empty   = (count == 3'd0);
    assign popAcc  = pop && !empty;
    assign pushAcc = push && (!full || popAcc);
    assign dOut    = mem[rdPtr];

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (pushAcc) mem[wrPtr] <= dIn;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= 2'd0;
            rdPtr <= 2'd0;
            count <= 3'd0;
        end else begin
            if (pushAcc) wrPtr <= wrPtr + 2'd1;
            if (popAcc)  rdPtr <= rdPtr + 2'd1;
            count <= count + 3'(pushAcc) - 3'(popAcc);
        end
    end

endmodule

// File: rtl/bus_tx_port.sv
// bus_tx_port: CPU-mapped byte transmitter (data port + status port) feeding
// an async serial line through a 4-deep FIFO. TX_PARITY_EN adds an even-parity bit.
module bus_tx_port
    import nic8_bus_pkg::*;
#(
    parameter logic [7:0]  ADDR_DATA    = ADDR_DATA_DEF,
    parameter logic [7:0]  ADDR_STAT    = ADDR_STAT_DEF,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       storeMemBar,
    input  logic       assertDev,
    input  logic [7:0] addr,
    input  logic [7:0] dbusIn,
    output logic [7:0] dbusOut,
    output logic       dbusDrive,
    output logic       tx
);

    localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);

    txState_t   state, stateNext;
    logic       wrData, rdStat, pop, full, empty, overflow;
    logic       bitLast, bitStep, txBit;
    logic [2:0] count, bitIdx;
    logic [7:0] head, shiftReg, bitTimer;

    assign wrData = !storeMemBar && (addr == ADDR_DATA);
    assign rdStat = assertDev && (addr == ADDR_STAT);

    tx_fifo4 uFifo (
        .clk   (clk),
        .reset (reset),
        .push  (wrData),
        .pop   (pop),
        .dIn   (dbusIn),
        .dOut  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Setting beats clearing so an overflow is never lost to a concurrent read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        overflow <= 1'b0;
        else if (wrData && full && !pop)  overflow <= 1'b1;
        else if (rdStat)                  overflow <= 1'b0;
    end

    assign dbusDrive = rdStat;
    assign dbusOut   = rdStat ? statusByte(overflow, state != ST_IDLE, full, empty, count)
                              : 8'h00;

    assign bitLast = (bitTimer == TIMER_LAST);

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        txBit     = 1'b1;
        bitStep   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    stateNext = ST_START;
                end
            end
            ST_START: begin
                txBit = 1'b0;
                if (bitLast) stateNext = ST_DATA;
            end
            ST_DATA: begin
                txBit = shiftReg[bitIdx];
                if (bitLast) begin
                    bitStep = 1'b1;
`ifdef TX_PARITY_EN
                    if (bitIdx == 3'd7) stateNext = ST_PARITY;
`else
                    if (bitIdx == 3'd7) stateNext = ST_STOP;
`endif
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                txBit = ^shiftReg;
                if (bitLast) stateNext = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Back-to-back frames: pop straight into START, no idle bit.
                if (bitLast) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        stateNext = ST_START;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign tx = txBit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bitTimer <= 8'd0;
            bitIdx   <= 3'd0;
            shiftReg <= 8'h00;
        end else begin
            state <= stateNext;
            // Timer restarts on every state entry and on each DATA bit boundary.
            if (stateNext != state || state == ST_IDLE || bitLast) bitTimer <= 8'd0;
            else                                                   bitTimer <= bitTimer + 8'd1;
            if (bitStep) bitIdx   <= bitIdx + 3'd1;
            if (pop)     shiftReg <= head;
        end
    end

endmodule

// File: tb/tb_bus_tx_port.sv
// Directed bench for bus_tx_port: decode table, frame timing, FIFO overflow,
// pop/push coincidence, mid-frame reset. Follows TX_PARITY_EN if defined.
module tb_bus_tx_port;

    localparam int C = 4;
`ifdef TX_PARITY_EN
    localparam int FL = 11 * C;
`else
    localparam int FL = 10 * C;
`endif

    logic       clk = 1'b0;
    logic       reset, storeMemBar, assertDev;
    logic [7:0] addr, dbusIn, dbusOut;
    logic       dbusDrive, tx;

    int checks   = 0;
    int failures = 0;

    logic [7:0] txBytes [4];
    int         nTx;

    bus_tx_port #(.ADDR_DATA(8'hFE), .ADDR_STAT(8'hFF), .CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .reset       (reset),
        .storeMemBar (storeMemBar),
        .assertDev   (assertDev),
        .addr        (addr),
        .dbusIn      (dbusIn),
        .dbusOut     (dbusOut),
        .dbusDrive   (dbusDrive),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       smb;
        logic       ad;
        logic [7:0] addr;
        logic [7:0] din;
        logic       expDrive;
        logic [7:0] expOut;
        logic       expTx;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1; storeMemBar = 1'b1; assertDev = 1'b0; addr = 8'h00; dbusIn = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Write one byte to the data port; returns 1 ns after the capturing edge.
    task automatic wrByte(input logic [7:0] b);
        storeMemBar = 1'b0; addr = 8'hFE; dbusIn = b;
        @(posedge clk);
        #1 storeMemBar = 1'b1; addr = 8'h00;
    endtask

    task automatic chkStatus(input string name, input logic [7:0] exp);
        assertDev = 1'b1; addr = 8'hFF;
        #1 chk(name, dbusOut, exp);
        chk({name, " drive"}, 8'(dbusDrive), 8'h01);
        assertDev = 1'b0; addr = 8'h00;
    endtask

    // Expected line level after edge N+j, where edge N captured the first byte.
    function automatic logic expBit(input int j);
        int f, p;
        logic [7:0] b;
        if (j < 1) return 1'b1;
        f = (j - 1) / FL;
        p = (j - 1) % FL;
        if (f >= nTx) return 1'b1;
        b = txBytes[f];
        if (p < C)     return 1'b0;
        if (p < 9 * C) return b[(p - C) / C];
`ifdef TX_PARITY_EN
        if (p < 10 * C) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic runStream(input int jNow);
        for (int j = jNow; j <= nTx * FL + 1; j++) begin
            if (j > jNow) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("tx j=%0d", j), 8'(tx), 8'(expBit(j)));
        end
    endtask

    initial begin
        int lowCnt;

        vecs[0] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h10, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 8'hFE, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 8'h12, 8'h55, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h10, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 8'h7F, 8'h00, 1'b0, 8'h00, 1'b1};

        doReset();
        chk("reset tx", 8'(tx), 8'h01);
        chk("reset dbusOut idle", dbusOut, 8'h00);

        // Bus decode table; entry 3 is a write to an unmapped address.
        foreach (vecs[i]) begin
            storeMemBar = vecs[i].smb; assertDev = vecs[i].ad;
            addr = vecs[i].addr; dbusIn = vecs[i].din;
            #1;
            chk($sformatf("vec%0d drive", i), 8'(dbusDrive), 8'(vecs[i].expDrive));
            chk($sformatf("vec%0d dbusOut", i), dbusOut, vecs[i].expOut);
            chk($sformatf("vec%0d tx", i), 8'(tx), 8'(vecs[i].expTx));
            @(posedge clk);
            #1;
        end
        storeMemBar = 1'b1; assertDev = 1'b0; addr = 8'h00;

        // Single frame of A5, then single frame of 07.
        txBytes[0] = 8'hA5; nTx = 1;
        wrByte(8'hA5);
        runStream(0);
        chkStatus("idle after A5", 8'h10);
        txBytes[0] = 8'h07; nTx = 1;
        wrByte(8'h07);
        runStream(0);
        chkStatus("idle after 07", 8'h10);

        // Back-to-back frames: second START immediately after first STOP.
        txBytes[0] = 8'h5A; txBytes[1] = 8'hC3; nTx = 2;
        wrByte(8'h5A);
        wrByte(8'hC3);
        runStream(1);
        chkStatus("idle after pair", 8'h10);

        // Fill: five writes -> one popped, four queued; sixth overflows.
        doReset();
        for (int i = 0; i < 5; i++) wrByte(8'(8'h10 + i));
        chkStatus("full no ovf", 8'h64);
        wrByte(8'h99);
        assertDev = 1'b1; addr = 8'hFF;
        #1 chk("ovf set", dbusOut, 8'hE4);
        @(posedge clk);
        #1 chk("ovf cleared by read", dbusOut, 8'h64);
        assertDev = 1'b0; addr = 8'h00;
        // Now at edge N+6; first frame pops the next byte at edge N+41.
        repeat (34) @(posedge clk);
        #1 wrByte(8'h77);
        chk("coincident pop tx start", 8'(tx), 8'h00);
        chkStatus("coincident push kept", 8'h64);

        // Mid-frame reset with two bytes queued behind 3C.
        doReset();
        wrByte(8'h3C);
        wrByte(8'h11);
        wrByte(8'h22);
        repeat (18) @(posedge clk);
        #1 chk("pre-reset in data", 8'(tx), 8'((8'h3C >> ((20 - 1 - C) / C)) & 8'h01));
        reset = 1'b1;
        #1 chk("async reset tx", 8'(tx), 8'h01);
        chkStatus("status in reset", 8'h10);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chkStatus("status after reset", 8'h10);
        lowCnt = 0;
        repeat (3 * FL) begin
            @(posedge clk);
            #1 if (tx !== 1'b1) lowCnt++;
        end
        chk("no frames after reset", 8'(lowCnt), 8'h00);
        chkStatus("status still empty", 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_tx_port.md
BUS_TX_PORT -- requirements
Module: bus_tx_port

Interface
REQ-001 Parameter ADDR_DATA, default 8'hFE, data-port address; a write here queues one byte.
REQ-002 Parameter ADDR_STAT, default 8'hFF, status-port address; read-only.
REQ-003 Parameter CLKS_PER_BIT, default 4, clocks per serial bit; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 storeMemBar  input  1  active-low CPU write strobe.
REQ-007 assertDev  input  1  active-high CPU read enable.
REQ-008 addr  input  8  CPU address (xreg).
REQ-009 dbusIn  input  8  CPU data bus value during writes.
REQ-010 dbusOut  output  8  read data; 8'h00 when not driving.
REQ-011 dbusDrive  output  1  high exactly when assertDev=1 and addr==ADDR_STAT (combinational).
REQ-012 tx  output  1  serial line, idle high.

Function
REQ-013 Write: at an edge with storeMemBar=0 and addr==ADDR_DATA, push dbusIn into a 4-entry FIFO.
REQ-014 Full push: dropped and sticky overflow set, unless a pop occurs on the same edge, in which case the push is accepted.
REQ-015 Writes to any other address are ignored.
REQ-016 Status byte: bit7 overflow, bit6 busy (FSM not IDLE), bit5 full, bit4 empty, bit3 0, bits2:0 FIFO count 0..4.
REQ-017 An edge with a status read active clears overflow; an overflow set on the same edge wins.
REQ-018 FSM states: IDLE, START, DATA, PARITY (only with TX_PARITY_EN), STOP.
REQ-019 IDLE: tx=1; if FIFO non-empty, pop head into the shift register and enter START.
REQ-020 START: tx=0 for CLKS_PER_BIT clocks, then DATA.
REQ-021 DATA: 8 bits LSB first, each CLKS_PER_BIT clocks; then PARITY if enabled, else STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT clocks; then, if FIFO non-empty, pop and enter START with no idle gap; else IDLE.
REQ-023 Latency: a write captured at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1, and tx falls after edge N+1.
REQ-024 Frame length: 10*CLKS_PER_BIT clocks; 11*CLKS_PER_BIT with parity.
REQ-025 Bit timer: a counter reloads on every state entry; the bit index wraps 7->0 only on the exit from DATA.
REQ-026 FIFO: read/write pointers are 2-bit and wrap modulo 4; count is 3-bit; empty when count==0, full when count==4.

Reset
REQ-027 Reset asserted, including mid-frame: FSM=IDLE, tx=1, FIFO emptied (pointers and count 0), overflow=0, bit timer and bit index 0, shift register 8'h00.
REQ-028 After reset: dbusOut=8'h00, dbusDrive follows REQ-011, status reads 8'h10.

Configuration
REQ-029 Macro TX_PARITY_EN defined: a PARITY state follows DATA and sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks.
REQ-030 Macro TX_PARITY_EN undefined: the PARITY state, its logic and its timer reload are absent.

Structure
REQ-031 Shared package nic8_bus_pkg: the FSM state enum, the status bit-position constants, and the default port addresses.
REQ-032 Sub-module tx_fifo4 (4x8 FIFO with push, pop, count, full, empty) is instantiated once; FSM and bus decode stay in bus_tx_port.

Verification
REQ-033 Reset, then write 8'hA5 to 8'hFE with CLKS_PER_BIT=4 -> tx low from edge N+1 for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4 clocks; frame is 40 clocks.
REQ-034 Write 5 bytes on consecutive clocks while idle -> first byte popped, remaining 4 fill the FIFO with no overflow; a 6th write sets status bit7; a status read then clears it.
REQ-035 Write two bytes back to back -> the second start bit follows the first stop bit with zero idle clocks.
REQ-036 Assert reset midway through the DATA bits of 8'h3C with 2 bytes queued -> tx=1 immediately, status reads 8'h10, no further frames.
REQ-037 With FIFO full, the write coincides with the STOP-to-START pop -> write accepted, count stays 4, overflow stays 0.
REQ-038 With TX_PARITY_EN, send 8'h07 -> parity bit 1 before stop; frame is 44 clocks at CLKS_PER_BIT=4.
